btn_cond: RTL and testbench

BTN_COND -- requirements
Module: btn_cond

---
 rtl/btn_cond_pkg.sv | 20 ++
 rtl/btn_cond_debounce_cell.sv | 123 ++++++++++++
 rtl/btn_cond.sv | 94 +++++++++
 tb/tb_btn_cond.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_cond_pkg.sv
// Shared definitions for the button/switch conditioner: the debounce cell
// state type and the default timing constants used by btn_cond and its cells.
package btn_cond_pkg;

    // Default number of consecutive stable samples needed to accept a change
    localparam int DEFAULT_DEB_CYCLES  = 4;
    // Default synchronizer depth for every raw asynchronous input
    localparam int DEFAULT_SYNC_STAGES = 2;

    // Debounce cell states; WAIT_RELEASE is the reset state so that a button
    // already held when reset lifts must be seen released before it can fire.
    typedef enum logic [2:0] {
        WAIT_RELEASE = 3'd0,
        IDLE         = 3'd1,
        PRESS_CHK    = 3'd2,
        HELD         = 3'd3,
        RELEASE_CHK  = 3'd4
    } cell_state_t;

endpackage

// File: rtl/btn_cond_debounce_cell.sv
// debounce_cell: one push button is synchronized, debounced and turned into a
// single registered one-cycle pulse per accepted press.
module debounce_cell
    import btn_cond_pkg::*;
#(
    parameter int DEB_CYCLES  = DEFAULT_DEB_CYCLES,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
)(
    input  logic CLK,
    input  logic RST_N,
    input  logic raw,
    output logic pulse
);

    localparam int              CNT_W   = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sample;
    cell_state_t            state;
    cell_state_t            state_nxt;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_nxt;
    logic [CNT_W-1:0]       cnt_inc;
    logic                   pulse_nxt;

    // Shift the raw button through the synchronizer chain
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], raw};
        end
    end

    assign sample  = sync_ff[SYNC_STAGES-1];
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + ONE;

    // State, sample counter and registered pulse
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= WAIT_RELEASE;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            pulse <= pulse_nxt;
        end
    end

    // Next-state logic; the sample that leaves IDLE or HELD already counts as
    // the first stable sample of the new level
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pulse_nxt = 1'b0;
        case (state)
            WAIT_RELEASE: begin
                if (sample) begin
                    cnt_nxt = '0;
                end else if (cnt_inc == CNT_MAX) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            IDLE: begin
                if (sample) begin
                    if (CNT_MAX == ONE) begin
                        state_nxt = HELD;
                        cnt_nxt   = '0;
                        pulse_nxt = 1'b1;
                    end else begin
                        state_nxt = PRESS_CHK;
                        cnt_nxt   = ONE;
                    end
                end
            end
            PRESS_CHK: begin
                if (!sample) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt_inc == CNT_MAX) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                    pulse_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            HELD: begin
                if (!sample) begin
                    if (CNT_MAX == ONE) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = RELEASE_CHK;
                        cnt_nxt   = ONE;
                    end
                end
            end
            RELEASE_CHK: begin
                if (sample) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else if (cnt_inc == CNT_MAX) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            default: begin
                state_nxt = WAIT_RELEASE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: rtl/btn_cond.sv
// btn_cond: conditions the Go/next push buttons and the mode-select switches
// for the controller FSM. Define BTN_COND_MS_DEBOUNCE_EN to debounce SW_MS as
// well; otherwise MS is simply the synchronized switch value.
module btn_cond
    import btn_cond_pkg::*;
#(
    parameter int DEB_CYCLES  = DEFAULT_DEB_CYCLES,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
)(
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       BTN_GO,
    input  logic       BTN_NEXT,
    input  logic [2:0] SW_MS,
    output logic       Go,
    output logic       next,
    output logic [2:0] MS
);

    logic [SYNC_STAGES-1:0][2:0] ms_sync_ff;
    logic [2:0]                  ms_sync;

    debounce_cell #(
        .DEB_CYCLES  (DEB_CYCLES),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_go_cell (
        .CLK   (CLK),
        .RST_N (RST_N),
        .raw   (BTN_GO),
        .pulse (Go)
    );

    debounce_cell #(
        .DEB_CYCLES  (DEB_CYCLES),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_next_cell (
        .CLK   (CLK),
        .RST_N (RST_N),
        .raw   (BTN_NEXT),
        .pulse (next)
    );

    // Synchronize the mode-select switches as one 3-bit word
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ms_sync_ff <= '0;
        end else begin
            ms_sync_ff <= {ms_sync_ff[SYNC_STAGES-2:0], SW_MS};
        end
    end

    assign ms_sync = ms_sync_ff[SYNC_STAGES-1];

`ifdef BTN_COND_MS_DEBOUNCE_EN
    localparam int               CNT_W   = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [2:0]       ms_last;
    logic [2:0]       ms_q;
    logic [CNT_W-1:0] ms_cnt;
    logic [CNT_W-1:0] ms_cnt_nxt;

    // Count how many consecutive samples have matched the current one
    always_comb begin
        ms_cnt_nxt = ms_cnt;
        if (ms_sync != ms_last) begin
            ms_cnt_nxt = ONE;
        end else if (ms_cnt != CNT_MAX) begin
            ms_cnt_nxt = ms_cnt + ONE;
        end
    end

    // Adopt the switch word only once it has been stable long enough
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ms_last <= 3'b000;
            ms_cnt  <= '0;
            ms_q    <= 3'b000;
        end else begin
            ms_last <= ms_sync;
            ms_cnt  <= ms_cnt_nxt;
            if (ms_cnt_nxt == CNT_MAX) begin
                ms_q <= ms_sync;
            end
        end
    end

    assign MS = ms_q;
`else
    assign MS = ms_sync;
`endif

endmodule

// File: tb/tb_btn_cond.sv
// Testbench for btn_cond. Expected outputs come from a level-based debounce
// reference model and are queued per cycle; a negedge monitor pops and
// compares them. Honours BTN_COND_MS_DEBOUNCE_EN for the MS model.
module tb_btn_cond;

    localparam int DEB  = 4;
    localparam int SYNC = 2;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       BTN_GO;
    logic       BTN_NEXT;
    logic [2:0] SW_MS;
    logic       Go;
    logic       next;
    logic [2:0] MS;

    int checks = 0;
    int errors = 0;
    int cycleNum = 0;
    int goPulses = 0;
    int nextPulses = 0;
    int lastGoCycle = -1;
    int lastNextCycle = -1;

    logic [4:0] expQ[$];
    logic [4:0] syncQ[$];
    logic [2:0] msHist[$];
    logic       goLevel;
    logic       nxLevel;
    int         goRun;
    int         nxRun;
    logic       goExp;
    logic       nxExp;
    logic [2:0] msExp;
    logic [4:0] curRaw;
    logic       curRst;

    always #5 CLK = ~CLK;

    btn_cond #(
        .DEB_CYCLES  (DEB),
        .SYNC_STAGES (SYNC)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .BTN_GO   (BTN_GO),
        .BTN_NEXT (BTN_NEXT),
        .SW_MS    (SW_MS),
        .Go       (Go),
        .next     (next),
        .MS       (MS)
    );

    // Reference model: a debounced level flips after DEB consecutive samples
    // disagreeing with it; a flip to pressed produces the pulse. Starting at
    // "pressed" means a button must first be seen released after reset.
    task automatic debStep(input logic s, input logic level, input int run,
                           output logic newLevel, output int newRun, output logic p);
        newLevel = level;
        newRun   = run;
        p        = 1'b0;
        if (s != level) begin
            newRun = run + 1;
            if (newRun >= DEB) begin
                newLevel = s;
                newRun   = 0;
                p        = s;
            end
        end else begin
            newRun = 0;
        end
    endtask

    task automatic modelReset();
        syncQ.delete();
        repeat (SYNC) syncQ.push_back(5'b00000);
        msHist.delete();
        goLevel = 1'b1;
        nxLevel = 1'b1;
        goRun   = 0;
        nxRun   = 0;
        goExp   = 1'b0;
        nxExp   = 1'b0;
        msExp   = 3'b000;
    endtask

    task automatic modelEdge(input logic [4:0] raw);
        logic [4:0] s;
        logic [4:0] head;
        logic       lv;
        int         rn;
        logic       p;
        logic       same;
        s = syncQ.pop_front();
        syncQ.push_back(raw);
        debStep(s[4], goLevel, goRun, lv, rn, p);
        goLevel = lv; goRun = rn; goExp = p;
        debStep(s[3], nxLevel, nxRun, lv, rn, p);
        nxLevel = lv; nxRun = rn; nxExp = p;
`ifdef BTN_COND_MS_DEBOUNCE_EN
        msHist.push_back(s[2:0]);
        if (msHist.size() > DEB) msHist.delete(0);
        if (msHist.size() == DEB) begin
            same = 1'b1;
            foreach (msHist[i]) if (msHist[i] != msHist[0]) same = 1'b0;
            if (same) msExp = msHist[0];
        end
        head = syncQ[0];
`else
        same = 1'b0;
        head = syncQ[0];
        msExp = head[2:0];
`endif
    endtask

    // One clock of stimulus: advance the model over the edge just taken,
    // drive the new inputs and queue the outputs expected for this cycle
    task automatic applyStimulus(input logic go, input logic nx,
                                 input logic [2:0] ms, input logic rstn);
        @(posedge CLK);
        #1;
        if (curRst) modelEdge(curRaw);
        cycleNum = cycleNum + 1;
        BTN_GO   = go;
        BTN_NEXT = nx;
        SW_MS    = ms;
        RST_N    = rstn;
        curRaw   = {go, nx, ms};
        curRst   = rstn;
        if (!rstn) modelReset();
        expQ.push_back(rstn ? {goExp, nxExp, msExp} : 5'b00000);
    endtask

    task automatic checkOutput(input logic [4:0] exp);
        logic [4:0] act;
        act = {Go, next, MS};
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("[TB] FAIL cycle %0d {Go,next,MS}: got %b_%b_%03b expected %b_%b_%03b",
                     cycleNum, act[4], act[3], act[2:0], exp[4], exp[3], exp[2:0]);
        end
        if (Go === 1'b1) begin
            goPulses    = goPulses + 1;
            lastGoCycle = cycleNum;
        end
        if (next === 1'b1) begin
            nextPulses    = nextPulses + 1;
            lastNextCycle = cycleNum;
        end
    endtask

    task automatic checkValue(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: compare DUT outputs against the queued expectation every cycle
    always @(negedge CLK) begin
        if (expQ.size() != 0) checkOutput(expQ.pop_front());
    end

    initial begin
        int g0;
        int n0;
        logic rg;
        logic rn;
        logic [2:0] rm;
        logic rr;

        RST_N    = 1'b0;
        BTN_GO   = 1'b0;
        BTN_NEXT = 1'b0;
        SW_MS    = 3'b000;
        curRaw   = 5'b00000;
        curRst   = 1'b0;
        modelReset();

        $display("[TB] clean reset, next raised at edge 10");
        repeat (3) applyStimulus(1'b0, 1'b0, 3'b000, 1'b0);
        #1;
        checkValue("reset outputs", int'({Go, next, MS}), 0);
        applyStimulus(1'b0, 1'b0, 3'b000, 1'b1);
        cycleNum = 0;
        repeat (9) applyStimulus(1'b0, 1'b0, 3'b000, 1'b1);
        n0 = nextPulses;
        repeat (20) applyStimulus(1'b0, 1'b1, 3'b000, 1'b1);
        repeat (8) applyStimulus(1'b0, 1'b0, 3'b000, 1'b1);
        checkValue("next pulse cycle", lastNextCycle, 16);
        checkValue("next pulse count", nextPulses - n0, 1);

        $display("[TB] Go glitch then real press");
        g0 = goPulses;
        repeat (3) applyStimulus(1'b1, 1'b0, 3'b000, 1'b1);
        repeat (8) applyStimulus(1'b0, 1'b0, 3'b000, 1'b1);
        checkValue("go glitch pulses", goPulses - g0, 0);
        repeat (10) applyStimulus(1'b1, 1'b0, 3'b000, 1'b1);
        repeat (8) applyStimulus(1'b0, 1'b0, 3'b000, 1'b1);
        checkValue("go press pulses", goPulses - g0, 1);

        $display("[TB] Go held through reset release");
        repeat (3) applyStimulus(1'b1, 1'b0, 3'b000, 1'b0);
        g0 = goPulses;
        repeat (11) applyStimulus(1'b1, 1'b0, 3'b000, 1'b1);
        checkValue("go held at reset pulses", goPulses - g0, 0);
        repeat (6) applyStimulus(1'b0, 1'b0, 3'b000, 1'b1);
        repeat (10) applyStimulus(1'b1, 1'b0, 3'b000, 1'b1);
        repeat (8) applyStimulus(1'b0, 1'b0, 3'b000, 1'b1);
        checkValue("go repress pulses", goPulses - g0, 1);

        $display("[TB] simultaneous Go and next");
        g0 = goPulses;
        n0 = nextPulses;
        repeat (10) applyStimulus(1'b1, 1'b1, 3'b000, 1'b1);
        repeat (8) applyStimulus(1'b0, 1'b0, 3'b000, 1'b1);
        checkValue("both go pulses", goPulses - g0, 1);
        checkValue("both next pulses", nextPulses - n0, 1);
        checkValue("both same cycle", lastGoCycle, lastNextCycle);

        $display("[TB] mode-select change and flicker");
        repeat (10) applyStimulus(1'b0, 1'b0, 3'b011, 1'b1);
        repeat (10) applyStimulus(1'b0, 1'b0, 3'b000, 1'b1);
        repeat (2) applyStimulus(1'b0, 1'b0, 3'b100, 1'b1);
        repeat (10) applyStimulus(1'b0, 1'b0, 3'b000, 1'b1);

        $display("[TB] reset during press check");
        g0 = goPulses;
        repeat (4) applyStimulus(1'b1, 1'b0, 3'b000, 1'b1);
        applyStimulus(1'b1, 1'b0, 3'b000, 1'b0);
        #1;
        checkValue("mid-debounce reset outputs", int'({Go, next, MS}), 0);
        repeat (2) applyStimulus(1'b0, 1'b0, 3'b000, 1'b0);
        repeat (12) applyStimulus(1'b0, 1'b0, 3'b000, 1'b1);
        checkValue("aborted press pulses", goPulses - g0, 0);

        $display("[TB] randomized phase");
        rg = 1'b0;
        rn = 1'b0;
        rm = 3'b000;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 4) == 0) rg = ~rg;
            if ($urandom_range(0, 4) == 0) rn = ~rn;
            if ($urandom_range(0, 7) == 0) rm = 3'($urandom_range(0, 7));
            rr = ($urandom_range(0, 149) != 0);
            applyStimulus(rg, rn, rm, rr);
        end
        repeat (4) applyStimulus(1'b0, 1'b0, 3'b000, 1'b1);
        @(negedge CLK);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
